// File: rtl/fetch_stage.sv
// RV64 instruction fetch stage: PC owner, single-outstanding imem handshake, IF/ID register.
// Optional performance counters are compiled in with FETCH_PERF_EN.
module fetch_stage #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_killed
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              kill_q, kill_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic [31:0]       hold_instr_q, hold_instr_d;
    logic              valid_d;
    logic [XLEN-1:0]   ifpc_d;
    logic [31:0]       instr_d;
    logic              fetched_ev, killed_ev;

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = {pc_q[XLEN-1:2], 2'b00};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        valid_d      = if_id_valid;
        ifpc_d       = if_id_pc;
        instr_d      = if_id_instr;
        fetched_ev   = 1'b0;
        killed_ev    = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (imem_gnt) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d    = 1'b0;
                        state_d   = S_REQ;
                        killed_ev = 1'b1;
                    end else if (!id_stall) begin
                        valid_d    = 1'b1;
                        ifpc_d     = pc_q;
                        instr_d    = imem_rdata;
                        pc_d       = pc_q + PC_STEP;
                        state_d    = S_REQ;
                        fetched_ev = 1'b1;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata;
                        pc_d         = pc_q + PC_STEP;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    valid_d    = 1'b1;
                    ifpc_d     = hold_pc_q;
                    instr_d    = hold_instr_q;
                    state_d    = S_REQ;
                    fetched_ev = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A redirect overrides everything above: flush IF/ID, drop the hold buffer, retarget PC.
        if (branch_taken) begin
            pc_d         = {branch_target[XLEN-1:2], 2'b00};
            valid_d      = 1'b0;
            ifpc_d       = if_id_pc;
            instr_d      = NOP_INSTR;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            fetched_ev   = 1'b0;
            killed_ev    = 1'b0;
            case (state_q)
                S_REQ: begin
                    state_d = imem_gnt ? S_WAIT : S_REQ;
                    kill_d  = imem_gnt;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        kill_d    = 1'b0;
                        killed_ev = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d   = S_REQ;
                    killed_ev = 1'b1;
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            if_id_valid  <= 1'b0;
            if_id_pc     <= '0;
            if_id_instr  <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            if_id_valid  <= valid_d;
            if_id_pc     <= ifpc_d;
            if_id_instr  <= instr_d;
        end
    end

    // The low target bits are discarded: fetch addresses are always word aligned.
`ifdef FETCH_PERF_EN
    logic [1:0] unused_target_bits;
    assign unused_target_bits = branch_target[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
        end else begin
            if (fetched_ev) perf_fetched <= perf_fetched + 32'd1;
            if (killed_ev)  perf_killed  <= perf_killed + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = ^{fetched_ev, killed_ev, branch_target[1:0]};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a zero-wait (optionally delayed) memory model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        id_stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;

    int n_checks = 0;
    int n_pass   = 0;

    int          pend_cnt  = 0;
    int          lat_extra = 0;
    logic [63:0] pend_addr = '0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Memory model: grants any request at once, answers 1 + lat_extra cycles later.
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end
        end
        imem_gnt = imem_req;
        if (imem_req) begin
            pend_cnt  = 1 + lat_extra;
            pend_addr = imem_addr;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   64'(imem_req),    64'd0);
        check({tag, "_addr"},  imem_addr,        64'd0);
        check({tag, "_valid"}, 64'(if_id_valid), 64'd0);
        check({tag, "_pc"},    if_id_pc,         64'd0);
        check({tag, "_instr"}, 64'(if_id_instr), 64'(NOP));
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; id_stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (2) tick();
        check_reset_outputs("rst");

        // Reset release, zero-wait memory, no stall
        rst_n = 1'b1;
        tick();
        check("st1_valid", 64'(if_id_valid), 64'd0);
        check("st1_req",   64'(imem_req),    64'd1);
        check("st1_addr",  imem_addr,        64'h0);
        tick();
        check("st2_valid", 64'(if_id_valid), 64'd0);
        check("st2_req",   64'(imem_req),    64'd0);
        tick();
        check("st3_valid", 64'(if_id_valid), 64'd1);
        check("st3_pc",    if_id_pc,         64'h0);
        check("st3_instr", 64'(if_id_instr), 64'(mem_word(64'h0)));
        check("st3_addr",  imem_addr,        64'h4);
        tick(); tick();
        check("seq_pc4",   if_id_pc,         64'h4);
        check("seq_addr8", imem_addr,        64'h8);
        tick(); tick();
        check("seq_pc8",   if_id_pc,         64'h8);
        check("seq_addrC", imem_addr,        64'hC);

        // Stall for 5 cycles while the response for 0xC returns
        id_stall = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("hold_req", 64'(imem_req), 64'd0);
            check("hold_pc",  if_id_pc,      64'h8);
            if (i < 3) tick();
        end
        id_stall = 1'b0;
        tick();
        check("rel_pc",    if_id_pc,         64'hC);
        check("rel_instr", 64'(if_id_instr), 64'(mem_word(64'hC)));
        check("rel_addr",  imem_addr,        64'h10);
        tick(); tick();
        check("rel_next_pc", if_id_pc, 64'h10);

        // Redirect to 0x100 in the grant cycle of 0x20
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 64'h20) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("find_20", 64'(found), 64'd1);
        branch_taken = 1'b1; branch_target = 64'h100;
        tick();
        branch_taken = 1'b0;
        check("br1_valid", 64'(if_id_valid), 64'd0);
        check("br1_instr", 64'(if_id_instr), 64'(NOP));
        check("br1_pc",    if_id_pc,         64'h1C);
        tick();
        check("br1_addr",   imem_addr,        64'h100);
        check("br1_req",    64'(imem_req),    64'd1);
        check("br1_valid2", 64'(if_id_valid), 64'd0);
        tick();
        check("br1_valid3", 64'(if_id_valid), 64'd0);
        lat_extra = 2;
        tick();
        check("br1_ld_pc",    if_id_pc,         64'h100);
        check("br1_ld_instr", 64'(if_id_instr), 64'(mem_word(64'h100)));

        // Redirect to 0x203 while WAIT has no response yet
        tick();
        branch_taken = 1'b1; branch_target = 64'h203;
        tick();
        branch_taken = 1'b0;
        lat_extra = 0;
        check("br2_valid", 64'(if_id_valid), 64'd0);
        tick();
        check("br2_req", 64'(imem_req), 64'd0);
        tick();
        check("br2_addr", imem_addr,     64'h200);
        check("br2_reqv", 64'(imem_req), 64'd1);
        tick(); tick();
        check("br2_ld_valid", 64'(if_id_valid), 64'd1);
        check("br2_ld_pc",    if_id_pc,         64'h200);
        check("br2_ld_instr", 64'(if_id_instr), 64'(mem_word(64'h200)));

        // Flush while stalled in HOLD
        id_stall = 1'b1;
        tick(); tick();
        check("hs_req", 64'(imem_req), 64'd0);
        branch_taken = 1'b1; branch_target = 64'h300;
        tick();
        branch_taken = 1'b0;
        check("hs_valid", 64'(if_id_valid), 64'd0);
        check("hs_instr", 64'(if_id_instr), 64'(NOP));
        check("hs_addr",  imem_addr,        64'h300);
        id_stall = 1'b0;
        tick(); tick();
        check("hs_ld_pc", if_id_pc, 64'h300);

        // PC wrap at the top of the address space
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        tick();
        check("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        lat_extra = 1;
        tick();
        check("wrap_pc",    if_id_pc,         64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_instr", 64'(if_id_instr), 64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
        check("wrap_addr0", imem_addr,        64'h0);

        // Asynchronous reset while waiting; the late response must be ignored
        tick();
        lat_extra = 0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_req",   64'(imem_req),    64'd1);
        check("post_addr",  imem_addr,        64'h0);
        check("post_valid", 64'(if_id_valid), 64'd0);
        check("post_instr", 64'(if_id_instr), 64'(NOP));
        tick(); tick();
        check("post_ld_valid", 64'(if_id_valid), 64'd1);
        check("post_ld_pc",    if_id_pc,         64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
